// File: rtl/pc_dma_pkg.sv
// Shared definitions for the receive-side DMA write master: FSM state
// encoding, bytes per bus word and default sizing constants.
package pc_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARMED     = 3'd1,
    ST_REQ       = 3'd2,
    ST_DATA      = 3'd3,
    ST_WAIT_DONE = 3'd4
  } dma_state_e;

  localparam int BYTES_PER_WORD      = 4;
  localparam int DEFAULT_BURST_WORDS = 16;
  localparam int DEFAULT_FIFO_DEPTH  = 64;

endpackage

// File: rtl/pc_sync_fifo.sv
// Show-ahead synchronous FIFO. The head word is presented combinationally on
// rdata; a push into a full FIFO is accepted when a pop happens in the same
// cycle. A synchronous clear empties it.
module pc_sync_fifo #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 32,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // Pointer and occupancy update; clear takes precedence over traffic.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

  // Storage and pointer registers; storage is zeroed so the head reads 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_ok && !clear) mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/eth_rx_dma_wr.sv
// Ethernet receive DMA write master: buffers received words and writes them
// to DDR in bursts of up to BURST_WORDS at an incrementing address until the
// programmed byte budget is spent.
// Optional statistics outputs (o_word_cnt, o_drop_cnt) are built when the
// macro ETH_RX_DMA_STAT_EN is defined.
module eth_rx_dma_wr
  import pc_dma_pkg::*;
#(
  parameter int FIFO_DEPTH  = DEFAULT_FIFO_DEPTH,
  parameter int BURST_WORDS = DEFAULT_BURST_WORDS,
  parameter int ADDR_W      = 32
) (
  input  logic              i_sys_clk,
  input  logic              i_reset_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [31:0]       i_max_len,
  input  logic              i_rx_valid,
  input  logic [31:0]       i_rx_data,
  input  logic              i_rx_done,
  output logic              wr_req,
  input  logic              wr_ack,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_len,
  input  logic              wr_data_req,
  output logic [31:0]       wr_data,
  output logic              wr_data_ready,
  input  logic              wr_req_done,
  output logic              o_busy,
  output logic              o_overflow
`ifdef ETH_RX_DMA_STAT_EN
  ,
  output logic [31:0]       o_word_cnt,
  output logic [15:0]       o_drop_cnt
`endif
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int BRST_W = $clog2(BURST_WORDS) + 1;

  dma_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       remaining_q, remaining_d;
  logic [31:0]       len_q, len_d;
  logic [BRST_W-1:0] burst_q, burst_d;
  logic [BRST_W-1:0] beat_q, beat_d;
  logic              flush_pend_q, flush_pend_d;
  logic              overflow_q, overflow_d;

  logic              fifo_clear;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [31:0]       fifo_rdata;

  logic              busy;
  logic              rx_drop;
  logic              start_ok;
  logic [31:0]       count32;
  logic [31:0]       need32;
  logic [31:0]       burst32;
  logic              can_issue;
  logic [31:0]       rem_after;

  assign busy      = (state_q != ST_IDLE);
  assign start_ok  = (state_q == ST_IDLE) && i_start;
  assign fifo_push = busy && i_rx_valid;
  assign fifo_pop  = (state_q == ST_DATA) && wr_data_req && !fifo_empty;
  assign rx_drop   = busy && i_rx_valid && fifo_full && !fifo_pop;

  assign count32   = 32'(fifo_count);
  assign need32    = (remaining_q < 32'(BURST_WORDS)) ? remaining_q : 32'(BURST_WORDS);
  assign burst32   = (count32 < need32) ? count32 : need32;
  assign can_issue = (count32 >= need32) || (flush_pend_q && (count32 != 32'd0));
  assign rem_after = remaining_q - 32'(burst_q);

  assign wr_req        = (state_q == ST_REQ);
  assign wr_addr       = addr_q;
  assign wr_len        = len_q;
  assign wr_data       = fifo_rdata;
  assign wr_data_ready = (state_q == ST_DATA) && !fifo_empty;
  assign o_busy        = busy;
  assign o_overflow    = overflow_q;

  pc_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (i_sys_clk),
    .rst_n (i_reset_n),
    .clear (fifo_clear),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (i_rx_data),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next-state, burst sizing and address/budget bookkeeping.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    remaining_d  = remaining_q;
    len_d        = len_q;
    burst_d      = burst_q;
    beat_d       = beat_q;
    flush_pend_d = flush_pend_q;
    overflow_d   = overflow_q;
    fifo_clear   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          addr_d       = i_base_addr;
          remaining_d  = i_max_len >> 2;
          fifo_clear   = 1'b1;
          overflow_d   = 1'b0;
          flush_pend_d = 1'b0;
          if ((i_max_len >> 2) != 32'd0) state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (can_issue) begin
          burst_d = BRST_W'(burst32);
          beat_d  = BRST_W'(burst32);
          len_d   = burst32 * 32'(BYTES_PER_WORD);
          state_d = ST_REQ;
          if (burst32 == count32) flush_pend_d = 1'b0;
        end else if (fifo_empty) begin
          flush_pend_d = 1'b0;
        end
      end
      ST_REQ: begin
        if (wr_ack) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (fifo_pop) begin
          beat_d = beat_q - BRST_W'(1);
          if (beat_q == BRST_W'(1)) state_d = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (wr_req_done) begin
          addr_d      = addr_q + ADDR_W'(32'(burst_q) * 32'(BYTES_PER_WORD));
          remaining_d = rem_after;
          state_d     = (rem_after == 32'd0) ? ST_IDLE : ST_ARMED;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (busy && i_rx_done) flush_pend_d = 1'b1;
    if (rx_drop)           overflow_d   = 1'b1;
  end

  // Control and datapath registers.
  always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      remaining_q  <= '0;
      len_q        <= '0;
      burst_q      <= '0;
      beat_q       <= '0;
      flush_pend_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      remaining_q  <= remaining_d;
      len_q        <= len_d;
      burst_q      <= burst_d;
      beat_q       <= beat_d;
      flush_pend_q <= flush_pend_d;
      overflow_q   <= overflow_d;
    end
  end

`ifdef ETH_RX_DMA_STAT_EN
  logic [31:0] word_cnt_q, word_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // Statistics: words handed to DDR and saturating count of dropped words.
  always_comb begin
    word_cnt_d = word_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (start_ok) begin
      word_cnt_d = '0;
      drop_cnt_d = '0;
    end else begin
      if (fifo_pop) word_cnt_d = word_cnt_q + 32'd1;
      if (rx_drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  // Statistics registers.
  always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      word_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      word_cnt_q <= word_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign o_word_cnt = word_cnt_q;
  assign o_drop_cnt = drop_cnt_q;
`else
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
`endif

endmodule

// File: tb/tb_eth_rx_dma_wr.sv
// Self-checking bench for eth_rx_dma_wr: a DDR port model consumes requests
// and data and compares them against scoreboard queues filled by the stimulus.
module tb_eth_rx_dma_wr;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_start = 1'b0;
   logic [31:0] i_base_addr = '0;
   logic [31:0] i_max_len = '0;
   logic        i_rx_valid = 1'b0;
   logic [31:0] i_rx_data = '0;
   logic        i_rx_done = 1'b0;
   logic        wr_req;
   logic        wr_ack;
   logic [31:0] wr_addr;
   logic [31:0] wr_len;
   logic        wr_data_req;
   logic [31:0] wr_data;
   logic        wr_data_ready;
   logic        wr_req_done;
   logic        o_busy;
   logic        o_overflow;
`ifdef ETH_RX_DMA_STAT_EN
   logic [31:0] o_word_cnt;
   logic [15:0] o_drop_cnt;
`endif

   int checks = 0;
   int failures = 0;
   int seq = 0;
   int done_cnt = 0;
   bit hold_ack = 1'b0;
   bit pause_pop = 1'b0;
   logic [31:0] exp_words[$];
   logic [31:0] exp_addr[$];
   logic [31:0] exp_len[$];

   // Free-running 100 MHz clock
   always #5 clk = ~clk;

   eth_rx_dma_wr dut (
      .i_sys_clk     (clk),
      .i_reset_n     (rst_n),
      .i_start       (i_start),
      .i_base_addr   (i_base_addr),
      .i_max_len     (i_max_len),
      .i_rx_valid    (i_rx_valid),
      .i_rx_data     (i_rx_data),
      .i_rx_done     (i_rx_done),
      .wr_req        (wr_req),
      .wr_ack        (wr_ack),
      .wr_addr       (wr_addr),
      .wr_len        (wr_len),
      .wr_data_req   (wr_data_req),
      .wr_data       (wr_data),
      .wr_data_ready (wr_data_ready),
      .wr_req_done   (wr_req_done),
      .o_busy        (o_busy),
      .o_overflow    (o_overflow)
`ifdef ETH_RX_DMA_STAT_EN
      ,
      .o_word_cnt    (o_word_cnt),
      .o_drop_cnt    (o_drop_cnt)
`endif
   );

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Queue an expected DDR request
   task automatic expectReq(input logic [31:0] addr, input logic [31:0] len);
      exp_addr.push_back(addr);
      exp_len.push_back(len);
   endtask

   // Pulse i_start with a base address and byte budget (called at a negedge)
   task automatic startTransfer(input logic [31:0] base, input logic [31:0] len);
      i_start = 1'b1;
      i_base_addr = base;
      i_max_len = len;
      @(negedge clk);
      i_start = 1'b0;
   endtask

   // Drive n back-to-back words; the first n_exp are expected at DDR in order
   task automatic applyStimulus(input int n, input int n_exp, input bit send_done);
      logic [31:0] w;
      for (int i = 0; i < n; i++) begin
         w = 32'h5A00_0000 | 32'(seq);
         seq++;
         i_rx_valid = 1'b1;
         i_rx_data = w;
         if (i < n_exp) exp_words.push_back(w);
         @(negedge clk);
      end
      i_rx_valid = 1'b0;
      if (send_done) begin
         i_rx_done = 1'b1;
         @(negedge clk);
         i_rx_done = 1'b0;
      end
   endtask

   // Bounded wait for the transfer to finish
   task automatic waitIdle(input string tag, input int budget);
      for (int i = 0; i < budget && o_busy; i++) @(negedge clk);
      checkOutput(tag, o_busy, 0);
   endtask

   // Bounded wait for burst data to become available
   task automatic waitReady(input string tag, input int budget);
      for (int i = 0; i < budget && !wr_data_ready; i++) @(negedge clk);
      checkOutput(tag, wr_data_ready, 1);
   endtask

   // Bounded wait for a given number of completed bursts
   task automatic waitDone(input string tag, input int target, input int budget);
      for (int i = 0; i < budget && done_cnt < target; i++) @(negedge clk);
      checkOutput(tag, done_cnt, target);
   endtask

   // DDR write-port model: acks requests, pops words, then signals completion
   initial begin : ddr_model
      int phase;
      int beats_left;
      int delay;
      logic [31:0] ea;
      logic [31:0] el;
      logic [31:0] ew;
      phase = 0;
      beats_left = 0;
      delay = 0;
      wr_ack = 1'b0;
      wr_data_req = 1'b0;
      wr_req_done = 1'b0;
      forever begin
         @(negedge clk);
         wr_ack = 1'b0;
         wr_data_req = 1'b0;
         wr_req_done = 1'b0;
         if (!rst_n) begin
            phase = 0;
            beats_left = 0;
         end else begin
            case (phase)
               0: if (wr_req && !hold_ack) begin
                  wr_ack = 1'b1;
                  if (exp_addr.size() == 0) begin
                     checkOutput("req_pending", exp_addr.size(), 1);
                  end else begin
                     ea = exp_addr.pop_front();
                     el = exp_len.pop_front();
                     checkOutput("req_addr", wr_addr, ea);
                     checkOutput("req_len", wr_len, el);
                  end
                  beats_left = int'(wr_len >> 2);
                  phase = 1;
               end
               1: if (beats_left == 0) begin
                  phase = 2;
                  delay = 2;
               end else if (wr_data_ready && !pause_pop) begin
                  wr_data_req = 1'b1;
                  if (exp_words.size() == 0) begin
                     checkOutput("word_pending", exp_words.size(), 1);
                  end else begin
                     ew = exp_words.pop_front();
                     checkOutput("wr_data", wr_data, ew);
                  end
                  beats_left--;
               end
               default: if (delay > 0) begin
                  delay--;
               end else begin
                  wr_req_done = 1'b1;
                  done_cnt++;
                  phase = 0;
               end
            endcase
         end
      end
   end

   // Watchdog so a stuck design still ends the run
   initial begin
      #300000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main test sequence
   initial begin
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rst_wr_req", wr_req, 0);
      checkOutput("rst_wr_addr", wr_addr, 0);
      checkOutput("rst_wr_len", wr_len, 0);
      checkOutput("rst_ready", wr_data_ready, 0);
      checkOutput("rst_busy", o_busy, 0);
      checkOutput("rst_overflow", o_overflow, 0);
      checkOutput("rst_wr_data", wr_data, 0);
`ifdef ETH_RX_DMA_STAT_EN
      checkOutput("rst_word_cnt", o_word_cnt, 0);
      checkOutput("rst_drop_cnt", o_drop_cnt, 0);
`endif
      rst_n = 1'b1;
      @(negedge clk);

      $display("[TB] two full bursts");
      expectReq(32'h1000, 64);
      expectReq(32'h1040, 64);
      startTransfer(32'h1000, 128);
      checkOutput("t1_busy", o_busy, 1);
      applyStimulus(32, 32, 1'b0);
      waitIdle("t1_idle", 400);
      checkOutput("t1_overflow", o_overflow, 0);
`ifdef ETH_RX_DMA_STAT_EN
      checkOutput("t1_word_cnt", o_word_cnt, 32);
`endif

      $display("[TB] partial flush burst");
      expectReq(32'h2000, 20);
      startTransfer(32'h2000, 64);
      applyStimulus(5, 5, 1'b1);
      waitDone("t2_done", 3, 200);
      repeat (2) @(negedge clk);
      checkOutput("t2_busy_after", o_busy, 1);
      checkOutput("t2_no_req", wr_req, 0);
      expectReq(32'h2014, 44);
      applyStimulus(11, 11, 1'b0);
      waitIdle("t2_idle", 400);

      $display("[TB] budget smaller than data");
      expectReq(32'h3000, 24);
      startTransfer(32'h3000, 24);
      applyStimulus(10, 6, 1'b0);
      waitIdle("t3_idle", 400);

      $display("[TB] overflow while ack withheld");
      hold_ack = 1'b1;
      for (int i = 0; i < 4; i++) expectReq(32'h4000 + 32'(i * 64), 64);
      startTransfer(32'h4000, 256);
      applyStimulus(70, 64, 1'b0);
      repeat (30) @(negedge clk);
      checkOutput("t4_overflow", o_overflow, 1);
`ifdef ETH_RX_DMA_STAT_EN
      checkOutput("t4_drop_cnt", o_drop_cnt, 6);
`endif
      hold_ack = 1'b0;
      waitIdle("t4_idle", 600);
      checkOutput("t4_overflow_sticky", o_overflow, 1);

      $display("[TB] push and pop with FIFO full");
      hold_ack = 1'b1;
      for (int i = 0; i < 5; i++) expectReq(32'h6000 + 32'(i * 64), 64);
      startTransfer(32'h6000, 320);
      checkOutput("t5_overflow_clr", o_overflow, 0);
      applyStimulus(64, 64, 1'b0);
      repeat (5) @(negedge clk);
      hold_ack = 1'b0;
      waitReady("t5_ready", 50);
      applyStimulus(16, 16, 1'b0);
      checkOutput("t5_no_overflow", o_overflow, 0);
      waitIdle("t5_idle", 600);
`ifdef ETH_RX_DMA_STAT_EN
      checkOutput("t5_drop_cnt", o_drop_cnt, 0);
      checkOutput("t5_word_cnt", o_word_cnt, 80);
`endif

      $display("[TB] reset during data phase");
      pause_pop = 1'b1;
      expectReq(32'h7000, 64);
      startTransfer(32'h7000, 64);
      applyStimulus(16, 16, 1'b0);
      waitReady("t6_ready", 50);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("t6_wr_req", wr_req, 0);
      checkOutput("t6_ready", wr_data_ready, 0);
      checkOutput("t6_busy", o_busy, 0);
      checkOutput("t6_wr_addr", wr_addr, 0);
      checkOutput("t6_wr_len", wr_len, 0);
      checkOutput("t6_wr_data", wr_data, 0);
      exp_words.delete();
      @(negedge clk);
      pause_pop = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      expectReq(32'h5000, 32);
      startTransfer(32'h5000, 32);
      applyStimulus(8, 8, 1'b0);
      waitIdle("t6_idle", 400);

      checkOutput("words_left", exp_words.size(), 0);
      checkOutput("reqs_left", exp_addr.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/eth_rx_dma_wr.md
# eth_rx_dma_wr

Write-side DMA master between the Ethernet receive stream (32-bit words with a per-word valid and an end-of-packet pulse) and one DDR write port of the memory subsystem. It buffers received words in a local FIFO and packs them into bursts of up to `BURST_WORDS` words. Each burst is written to DDR at an incrementing address, starting from a software-programmed base, until a programmed byte budget is consumed. It runs in the DMA clock domain; the Ethernet receive data is already in this domain when it arrives.

## Interface
- `FIFO_DEPTH`, 64: receive FIFO depth in 32-bit words; power of two, at least 2×`BURST_WORDS`.
- `BURST_WORDS`, 16: maximum words per DDR write request.
- `ADDR_W`, 32: width of the DDR byte address.
- `i_sys_clk` in 1: single clock; all logic is on the rising edge.
- `i_reset_n` in 1: asynchronous, active-low reset.
- `i_start` in 1: one-cycle pulse; arms a transfer. Ignored while `o_busy`=1.
- `i_base_addr` in `ADDR_W`: start byte address; sampled on `i_start`.
- `i_max_len` in 32: byte budget; sampled on `i_start`; bits [1:0] are ignored (budget is whole words).
- `i_rx_valid` in 1: `i_rx_data` is valid this cycle.
- `i_rx_data` in 32: received word.
- `i_rx_done` in 1: end-of-packet pulse; requests a flush of any partial burst.
- `wr_req` out 1: burst request.
- `wr_ack` in 1: one-cycle pulse; the DDR port has accepted the request.
- `wr_addr` out `ADDR_W`: burst byte address.
- `wr_len` out 32: burst length in bytes (words×4).
- `wr_data_req` in 1: the DDR port pops one word this cycle.
- `wr_data` out 32: FIFO head word (show-ahead); valid whenever `wr_data_ready`=1.
- `wr_data_ready` out 1: the burst is in DATA state and the FIFO is not empty.
- `wr_req_done` in 1: one-cycle pulse; the burst is fully committed to DDR.
- `o_busy` out 1: a transfer is armed or in progress.
- `o_overflow` out 1: sticky; a word was dropped because the FIFO was full. Cleared by `i_start`.

## Operation
- States:
  - IDLE: wait for `i_start`.
  - ARMED: wait until a burst can be issued.
  - REQ: `wr_req` asserted.
  - DATA: burst words being popped.
  - WAIT_DONE: waiting for `wr_req_done`.
- IDLE→ARMED on `i_start`: latch address and remaining words (`i_max_len`>>2), clear the FIFO, clear `o_overflow` and flush_pend. If the budget is 0 words, stay in IDLE.
- Push: `i_rx_valid` while `o_busy`=1 and the FIFO is not full (or a pop happens the same cycle).
  - A word arriving while the FIFO is full with no pop is dropped and sets `o_overflow`.
  - Words arriving in IDLE are discarded silently.
- `i_rx_done` sets flush_pend (while `o_busy`=1).
- ARMED→REQ when count ≥ min(`BURST_WORDS`, remaining), or when flush_pend=1 and count>0.
  - burst_words = min(count, `BURST_WORDS`, remaining) is latched on entry.
  - `wr_addr` and `wr_len` are driven from registers and stay stable through WAIT_DONE.
- flush_pend clears when the FIFO is empty in ARMED, or when a flush burst is issued that empties the FIFO.
- REQ→DATA on `wr_ack`.
- DATA: each `wr_data_req` pops one word and decrements the burst counter. If `wr_data_req` arrives while the FIFO is empty, it is a protocol error: ignored, and no pop occurs. After the last word: →WAIT_DONE.
- WAIT_DONE→ on `wr_req_done`:
  - address += burst_words×4, remaining −= burst_words.
  - remaining=0 → IDLE; otherwise → ARMED.
- Address arithmetic wraps modulo 2^`ADDR_W`; 4 KB boundaries are not checked.

## Timing
- Reset values: `wr_req`=0, `wr_addr`=0, `wr_len`=0, `wr_data_ready`=0, `o_busy`=0, `o_overflow`=0, FIFO empty. `wr_data` follows the FIFO head (0 after reset).
- `wr_req` rises the cycle after the ARMED decision and stays high up to and including the `wr_ack` cycle; it is low the next cycle.
- `wr_data` is combinational from the FIFO head. The next word is visible the cycle after a pop, so back-to-back `wr_data_req` sustains 1 word/cycle.
- FIFO write-to-read latency is 1 cycle: a word pushed at cycle N is poppable at N+1.
- `o_busy` is high from the cycle after `i_start` until the cycle after the final `wr_req_done`.
- `wr_ack` or `wr_req_done` arriving in any other state is ignored.
- Asserting `i_reset_n` low mid-burst immediately drops `wr_req` and `wr_data_ready`. The DDR port must be reset together with this block.

## Configuration
- `ETH_RX_DMA_STAT_EN` defined: adds two outputs.
  - `o_word_cnt` (32): words written to DDR since `i_start`.
  - `o_drop_cnt` (16, saturating): words dropped on overflow.
  - Both reset to 0 and clear on `i_start`.
- Not defined: neither output nor their counters exist; all other behaviour is identical.

## Structure
- Shared package `pc_dma_pkg`: state enum, `BYTES_PER_WORD`=4, default burst and depth constants.
- One sub-module `pc_sync_fifo`: show-ahead synchronous FIFO with outputs count, full and empty, and simultaneous push/pop when full. The FSM, address/length counters and optional statistics stay in the top module.

## Test plan
- Base 0x1000, budget 128 B, 32 words back-to-back → two requests: (0x1000, 64) and (0x1040, 64); all words in order; `o_busy` low after the second `wr_req_done`.
- Budget 64 B, 5 words then `i_rx_done` → one request (addr, 20). After `wr_req_done`, state ARMED, `o_busy`=1, remaining 11 words.
- Budget 24 B, 10 words → one request of 24 B; the remaining 4 words stay in the FIFO and are discarded at the next `i_start`.
- `wr_ack` withheld 100 cycles while 70 words arrive (depth 64) → 6 drops, `o_overflow`=1; `o_drop_cnt`=6 with the STAT macro defined.
- Push and pop on the same cycle with the FIFO full → no drop, count unchanged.
- Reset asserted during DATA → all outputs at reset values the same cycle; a new `i_start` runs cleanly.
